// File: rtl/riscv_lsu_pkg.sv
// Shared types and constants for the riscv_lsu load/store unit and its lane-steering helper.
package riscv_lsu_pkg;

   typedef enum logic [2:0] {
      MASK_B      = 3'b000,
      MASK_H      = 3'b001,
      MASK_X      = 3'b010,
      MASK_B_SEXT = 3'b100,
      MASK_H_SEXT = 3'b101
   } MASK_SEL;

   typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} LSU_STATE;

   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} ACC_SIZE;

   localparam logic [3:0] LSU_STRB_B = 4'b0001;
   localparam logic [3:0] LSU_STRB_H = 4'b0011;
   localparam logic [3:0] LSU_STRB_W = 4'b1111;

   // Unlisted MASK_SEL encodings fall back to a full-word access.
   function automatic ACC_SIZE accSize(input MASK_SEL maskSel);
      case (maskSel)
         MASK_B, MASK_B_SEXT: accSize = SZ_B;
         MASK_H, MASK_H_SEXT: accSize = SZ_H;
         default:             accSize = SZ_W;
      endcase
   endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational byte-lane steering: store strobes/replicated data and load right-alignment.
module riscv_lsu_align
   import riscv_lsu_pkg::*;
#(
   parameter int WORD_LENGTH = 32,
   parameter int STRB_WIDTH  = WORD_LENGTH / 8
) (
   input  ACC_SIZE                st_size_i,
   input  logic [1:0]             st_off_i,
   input  logic [WORD_LENGTH-1:0] st_data_i,
   output logic [STRB_WIDTH-1:0]  st_strb_o,
   output logic [WORD_LENGTH-1:0] st_data_o,
   input  ACC_SIZE                ld_size_i,
   input  logic [1:0]             ld_off_i,
   input  logic [WORD_LENGTH-1:0] ld_rdata_i,
   output logic [WORD_LENGTH-1:0] ld_data_o
);

   // Half accesses only look at addr[1]; addr[0] is dropped, as are both bits for words.
   always_comb begin
      st_strb_o = LSU_STRB_W;
      st_data_o = st_data_i;
      case (st_size_i)
         SZ_B: begin
            st_strb_o = LSU_STRB_B << st_off_i;
            st_data_o = {4{st_data_i[7:0]}};
         end
         SZ_H: begin
            st_strb_o = LSU_STRB_H << {st_off_i[1], 1'b0};
            st_data_o = {2{st_data_i[15:0]}};
         end
         default: ;
      endcase
   end

   // Upper bits pass through unmasked; the downstream mask stage clears or extends them.
   always_comb begin
      ld_data_o = ld_rdata_i;
      case (ld_size_i)
         SZ_B:    ld_data_o = ld_rdata_i >> {ld_off_i, 3'b000};
         SZ_H:    ld_data_o = ld_rdata_i >> {ld_off_i[1], 4'b0000};
         default: ;
      endcase
   end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: one op at a time over a valid/ready RAM port, right-aligned load data out.
// Defining RISCV_LSU_MISALIGN_TRAP_EN adds a fault output that traps misaligned half/word ops.
module riscv_lsu
   import riscv_lsu_pkg::*;
#(
   parameter int WORD_LENGTH = 32,
   parameter int STRB_WIDTH  = WORD_LENGTH / 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_we,
   input  logic [WORD_LENGTH-1:0] req_addr,
   input  logic [WORD_LENGTH-1:0] req_wdata,
   input  MASK_SEL                req_mask_sel,
   output logic                   mem_req_valid,
   input  logic                   mem_req_ready,
   output logic [WORD_LENGTH-1:0] mem_addr,
   output logic                   mem_we,
   output logic [STRB_WIDTH-1:0]  mem_wstrb,
   output logic [WORD_LENGTH-1:0] mem_wdata,
   input  logic                   mem_rvalid,
   input  logic [WORD_LENGTH-1:0] mem_rdata,
   output logic [WORD_LENGTH-1:0] ram_data,
   output MASK_SEL                ram_mask_sel,
   output logic                   load_done,
   output logic                   store_done,
   output logic                   busy
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
   ,
   output logic                   fault
`endif
);

   LSU_STATE               state_q, state_d;
   logic [WORD_LENGTH-1:0] addr_q, addr_d;
   logic [WORD_LENGTH-1:0] wdata_q, wdata_d;
   logic [WORD_LENGTH-1:0] ramData_q, ramData_d;
   logic [STRB_WIDTH-1:0]  wstrb_q, wstrb_d;
   ACC_SIZE                size_q, size_d;
   MASK_SEL                maskSel_q, maskSel_d;
   MASK_SEL                ramMaskSel_q, ramMaskSel_d;
   logic                   we_q, we_d;
   logic                   trapped;

   ACC_SIZE                reqSize;
   logic [STRB_WIDTH-1:0]  stStrb;
   logic [WORD_LENGTH-1:0] stData;
   logic [WORD_LENGTH-1:0] ldData;

   assign reqSize = accSize(req_mask_sel);

   riscv_lsu_align #(
      .WORD_LENGTH(WORD_LENGTH),
      .STRB_WIDTH (STRB_WIDTH)
   ) u_align (
      .st_size_i (reqSize),
      .st_off_i  (req_addr[1:0]),
      .st_data_i (req_wdata),
      .st_strb_o (stStrb),
      .st_data_o (stData),
      .ld_size_i (size_q),
      .ld_off_i  (addr_q[1:0]),
      .ld_rdata_i(mem_rdata),
      .ld_data_o (ldData)
   );

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
   logic fault_q, fault_d;
   assign trapped = fault_q;
   assign fault   = (state_q == DONE) && fault_q;
`else
   assign trapped = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      size_d       = size_q;
      maskSel_d    = maskSel_q;
      we_d         = we_q;
      ramData_d    = ramData_q;
      ramMaskSel_d = ramMaskSel_q;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
      fault_d      = fault_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d    = req_addr;
               size_d    = reqSize;
               maskSel_d = req_mask_sel;
               we_d      = req_we;
               wstrb_d   = stStrb;
               wdata_d   = stData;
               state_d   = REQ;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
               fault_d   = ((reqSize == SZ_H) && req_addr[0]) ||
                           ((reqSize == SZ_W) && (req_addr[1:0] != 2'b00));
               if (fault_d) state_d = DONE;
`endif
            end
         end
         REQ: begin
            // A zero-wait RAM may return read data in the same cycle it accepts the request.
            if (mem_req_ready) begin
               if (we_q) begin
                  state_d = DONE;
               end else if (mem_rvalid) begin
                  ramData_d    = ldData;
                  ramMaskSel_d = maskSel_q;
                  state_d      = DONE;
               end else begin
                  state_d = WAIT_R;
               end
            end
         end
         WAIT_R: begin
            if (mem_rvalid) begin
               ramData_d    = ldData;
               ramMaskSel_d = maskSel_q;
               state_d      = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         size_q       <= SZ_W;
         maskSel_q    <= MASK_X;
         we_q         <= 1'b0;
         ramData_q    <= '0;
         ramMaskSel_q <= MASK_X;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
         fault_q      <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         size_q       <= size_d;
         maskSel_q    <= maskSel_d;
         we_q         <= we_d;
         ramData_q    <= ramData_d;
         ramMaskSel_q <= ramMaskSel_d;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
         fault_q      <= fault_d;
`endif
      end
   end

   assign req_ready     = (state_q == IDLE);
   assign busy          = (state_q != IDLE);
   assign mem_req_valid = (state_q == REQ);
   assign mem_addr      = {addr_q[WORD_LENGTH-1:2], 2'b00};
   assign mem_we        = we_q;
   assign mem_wstrb     = wstrb_q;
   assign mem_wdata     = wdata_q;
   assign ram_data      = ramData_q;
   assign ram_mask_sel  = ramMaskSel_q;
   assign load_done     = (state_q == DONE) && !we_q && !trapped;
   assign store_done    = (state_q == DONE) && we_q && !trapped;

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: random ops against a transaction-level model plus directed cases.
// Define RISCV_LSU_MISALIGN_TRAP_EN for both RTL and bench to exercise the fault output.
module tb_riscv_lsu;
   import riscv_lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   MASK_SEL     req_mask_sel;
   logic        mem_req_valid, mem_req_ready, mem_we, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, ram_data;
   logic [3:0]  mem_wstrb;
   MASK_SEL     ram_mask_sel;
   logic        load_done, store_done, busy;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
   logic        fault;
   logic        expFault, sampFault;
`endif

   int          compared = 0;
   int          mismatched = 0;
   int          cyc = 0;
   bit          checkEn = 1'b0;

   logic        expBusy, expReqValid, expLoadDone, expStoreDone, expWe;
   logic [31:0] expMemAddr, expWdata, expRamData;
   logic [3:0]  expWstrb;
   MASK_SEL     expRamMask;

   int          acceptCyc, doneCyc;
   logic [31:0] sampAddr, sampWdata;
   logic [3:0]  sampWstrb;
   logic        sampWe;

   riscv_lsu dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_mask_sel (req_mask_sel),
      .mem_req_valid(mem_req_valid),
      .mem_req_ready(mem_req_ready),
      .mem_addr     (mem_addr),
      .mem_we       (mem_we),
      .mem_wstrb    (mem_wstrb),
      .mem_wdata    (mem_wdata),
      .mem_rvalid   (mem_rvalid),
      .mem_rdata    (mem_rdata),
      .ram_data     (ram_data),
      .ram_mask_sel (ram_mask_sel),
      .load_done    (load_done),
      .store_done   (store_done),
      .busy         (busy)
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
      ,
      .fault        (fault)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
      end
   endtask

   task automatic compareAll();
      checkOutput("busy",          32'(busy),          32'(expBusy));
      checkOutput("req_ready",     32'(req_ready),     32'(!expBusy));
      checkOutput("mem_req_valid", 32'(mem_req_valid), 32'(expReqValid));
      checkOutput("load_done",     32'(load_done),     32'(expLoadDone));
      checkOutput("store_done",    32'(store_done),    32'(expStoreDone));
      checkOutput("ram_data",      ram_data,           expRamData);
      checkOutput("ram_mask_sel",  32'(ram_mask_sel),  32'(expRamMask));
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
      checkOutput("fault",         32'(fault),         32'(expFault));
`endif
      if (expReqValid) begin
         checkOutput("mem_addr",  mem_addr,        expMemAddr);
         checkOutput("mem_we",    32'(mem_we),     32'(expWe));
         checkOutput("mem_wstrb", 32'(mem_wstrb),  32'(expWstrb));
         checkOutput("mem_wdata", mem_wdata,       expWdata);
      end
   endtask

   function automatic int bytesOf(input MASK_SEL m);
      case (m)
         MASK_B, MASK_B_SEXT: return 1;
         MASK_H, MASK_H_SEXT: return 2;
         default:             return 4;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic noise();
      mem_req_ready = 1'($urandom_range(0, 1));
      mem_rvalid    = 1'($urandom_range(0, 1));
      mem_rdata     = $urandom;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         req_valid = 1'b0;
         noise();
         step();
      end
   endtask

   task automatic setIdleExpect();
      expBusy      = 1'b0;
      expReqValid  = 1'b0;
      expLoadDone  = 1'b0;
      expStoreDone = 1'b0;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
      expFault     = 1'b0;
`endif
   endtask

   // Drives one op from an idle cycle through its done cycle and leaves the DUT idle.
   task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input MASK_SEL mask, input int readyDelay, input int rvalidLat,
                                input logic [31:0] rdata);
      int nb;
      int start;
      nb    = bytesOf(mask);
      start = (nb == 4) ? 0 : (int'(addr[1:0]) & ~(nb - 1));
      expMemAddr = addr & 32'hFFFF_FFFC;
      expWe      = we;
      for (int i = 0; i < 4; i++) begin
         expWstrb[i]        = (i >= start) && (i < start + nb);
         expWdata[8*i +: 8] = wdata[8*(i % nb) +: 8];
      end

      req_valid    = 1'b1;
      req_we       = we;
      req_addr     = addr;
      req_wdata    = wdata;
      req_mask_sel = mask;
      noise();
      setIdleExpect();
      acceptCyc = cyc;
      step();

      req_we       = 1'($urandom);
      req_addr     = $urandom;
      req_wdata    = $urandom;
      req_mask_sel = MASK_SEL'(3'($urandom_range(0, 7)));

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
      if ((int'(addr[1:0]) % nb) != 0) begin
         expBusy  = 1'b1;
         expFault = 1'b1;
         req_valid = 1'($urandom);
         noise();
         doneCyc = cyc;
         #3;
         sampFault = fault;
         step();
         req_valid = 1'b0;
         setIdleExpect();
         return;
      end
`endif

      for (int i = 0; i <= readyDelay; i++) begin
         expBusy       = 1'b1;
         expReqValid   = 1'b1;
         req_valid     = 1'($urandom);
         mem_req_ready = (i == readyDelay);
         mem_rvalid    = 1'b0;
         mem_rdata     = $urandom;
         if (i == readyDelay) begin
            if (we) begin
               mem_rvalid = 1'($urandom);
            end else if (rvalidLat == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = rdata;
            end
         end
         if (i == 0) begin
            #3;
            sampAddr  = mem_addr;
            sampWstrb = mem_wstrb;
            sampWdata = mem_wdata;
            sampWe    = mem_we;
         end
         step();
      end
      expReqValid = 1'b0;

      if (!we) begin
         for (int i = 1; i <= rvalidLat; i++) begin
            req_valid     = 1'($urandom);
            mem_req_ready = 1'($urandom);
            mem_rvalid    = (i == rvalidLat);
            mem_rdata     = (i == rvalidLat) ? rdata : $urandom;
            step();
         end
         expRamData  = rdata >> (8 * start);
         expRamMask  = mask;
         expLoadDone = 1'b1;
      end else begin
         expStoreDone = 1'b1;
      end
      doneCyc   = cyc;
      req_valid = 1'($urandom);
      noise();
      step();
      req_valid = 1'b0;
      setIdleExpect();
   endtask

   initial begin
      req_valid     = 1'b0;
      req_we        = 1'b0;
      req_addr      = '0;
      req_wdata     = '0;
      req_mask_sel  = MASK_X;
      mem_req_ready = 1'b0;
      mem_rvalid    = 1'b0;
      mem_rdata     = '0;
      expRamData    = '0;
      expRamMask    = MASK_X;
      expWe         = 1'b0;
      expMemAddr    = '0;
      expWdata      = '0;
      expWstrb      = '0;
      setIdleExpect();

      fork
         forever begin
            @(negedge clk);
            if (checkEn) compareAll();
         end
         begin
            #1000000;
            $display("[TB] FAIL timeout: got no completion, expected finish before time limit");
            mismatched++;
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
            $finish;
         end
      join_none

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_req_ready",     32'(req_ready),     32'd1);
      checkOutput("rst_busy",          32'(busy),          32'd0);
      checkOutput("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
      checkOutput("rst_load_done",     32'(load_done),     32'd0);
      checkOutput("rst_store_done",    32'(store_done),    32'd0);
      checkOutput("rst_ram_data",      ram_data,           32'd0);
      checkOutput("rst_ram_mask_sel",  32'(ram_mask_sel),  32'(MASK_X));
      checkOutput("rst_mem_addr",      mem_addr,           32'd0);
      checkOutput("rst_mem_wstrb",     32'(mem_wstrb),     32'd0);
      checkOutput("rst_mem_wdata",     mem_wdata,          32'd0);
      checkOutput("rst_mem_we",        32'(mem_we),        32'd0);
      step();
      rst_n = 1'b1;
      step();
      checkEn = 1'b1;

      $display("[TB] directed: byte load, sign-extend select, zero-wait RAM");
      applyStimulus(1'b0, 32'h0000_1003, 32'h0, MASK_B_SEXT, 0, 0, 32'h80AA_BBCC);
      checkOutput("tp1_mem_addr",  sampAddr,              32'h0000_1000);
      checkOutput("tp1_ram_data",  ram_data,              32'h0000_0080);
      checkOutput("tp1_mask_sel",  32'(ram_mask_sel),     32'(MASK_B_SEXT));
      checkOutput("tp1_latency",   32'(doneCyc - acceptCyc), 32'd2);

      $display("[TB] directed: half store");
      applyStimulus(1'b1, 32'h0000_2002, 32'h0000_BEEF, MASK_H, 0, 0, 32'h0);
      checkOutput("tp2_wstrb",     32'(sampWstrb),        32'h0000_000C);
      checkOutput("tp2_wdata",     sampWdata,             32'hBEEF_BEEF);
      checkOutput("tp2_we",        32'(sampWe),           32'd1);
      checkOutput("tp2_latency",   32'(doneCyc - acceptCyc), 32'd2);

      $display("[TB] directed: byte store with RAM stalling three cycles");
      applyStimulus(1'b1, 32'h0000_2401, 32'hCAFE_F00D, MASK_B, 3, 0, 32'h0);
      checkOutput("tp3_wstrb",     32'(sampWstrb),        32'h0000_0002);
      checkOutput("tp3_wdata",     sampWdata,             32'h0D0D_0D0D);
      checkOutput("tp3_latency",   32'(doneCyc - acceptCyc), 32'd5);

      $display("[TB] directed: word load with late read data");
      idleCycles(1);
      applyStimulus(1'b0, 32'h0000_5000, 32'h0, MASK_X, 0, 3, 32'h1234_5678);
      checkOutput("tp4_ram_data",  ram_data,              32'h1234_5678);
      checkOutput("tp4_latency",   32'(doneCyc - acceptCyc), 32'd5);

      $display("[TB] directed: reset while waiting for read data");
      checkEn       = 1'b0;
      req_valid     = 1'b1;
      req_we        = 1'b0;
      req_addr      = 32'h0000_4000;
      req_mask_sel  = MASK_X;
      mem_req_ready = 1'b0;
      mem_rvalid    = 1'b0;
      step();
      req_valid     = 1'b0;
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      #2;
      checkOutput("tp5_busy_before",  32'(busy),          32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("tp5_busy_async",   32'(busy),          32'd0);
      checkOutput("tp5_ready_async",  32'(req_ready),     32'd1);
      checkOutput("tp5_valid_async",  32'(mem_req_valid), 32'd0);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEAD_BEEF;
      step();
      rst_n = 1'b1;
      #3;
      checkOutput("tp5_load_done",    32'(load_done),     32'd0);
      checkOutput("tp5_ram_data",     ram_data,           32'd0);
      checkOutput("tp5_mask_sel",     32'(ram_mask_sel),  32'(MASK_X));
      step();
      mem_rvalid = 1'b0;
      #3;
      checkOutput("tp5_late_done",    32'(load_done),     32'd0);
      checkOutput("tp5_late_data",    ram_data,           32'd0);
      checkOutput("tp5_late_busy",    32'(busy),          32'd0);
      step();
      expRamData = '0;
      expRamMask = MASK_X;
      setIdleExpect();
      checkEn = 1'b1;

      $display("[TB] directed: word load at misaligned address 0x3001");
      applyStimulus(1'b0, 32'h0000_3001, 32'h0, MASK_X, 0, 0, 32'hA5A5_A5A5);
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
      checkOutput("tp6_fault",        32'(sampFault),     32'd1);
      checkOutput("tp6_latency",      32'(doneCyc - acceptCyc), 32'd1);
      checkOutput("tp6_ram_data",     ram_data,           32'd0);
`else
      checkOutput("tp6_mem_addr",     sampAddr,           32'h0000_3000);
      checkOutput("tp6_ram_data",     ram_data,           32'hA5A5_A5A5);
      checkOutput("tp6_latency",      32'(doneCyc - acceptCyc), 32'd2);
`endif

      $display("[TB] randomized ops");
      for (int n = 0; n < 300; n++) begin
         applyStimulus(1'($urandom), $urandom, $urandom, MASK_SEL'(3'($urandom_range(0, 7))),
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                       int'($urandom_range(0, 4)), $urandom);
         idleCycles(int'($urandom_range(0, 2)));
      end

      idleCycles(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
